hazard_scoreboard: RTL and testbench

Parametrised successor to the single-cycle load-use detector. It tracks in-flight register writes with per-register latency countdowns, and it stalls the decode stage while any source operand of the instruction in ID has a result that cannot yet be forwarded. It supports fixed multi-cycle producers (loads, multipliers) and variable-latency producers (divider, cache-miss loads) that release on writeback. It sits between the ID/EX pipeline register and the hazard/stall control that gates the PC and IF/ID enables.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/sb_entry.sv | 58 +++++
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the register hazard scoreboard: latency encodings
// carried on issue_lat and the per-register scoreboard entry layout.
package hazard_pkg;

    // Latency encodings presented on issue_lat.
    localparam int LAT_VAR  = 0;   // variable latency, released by writeback
    localparam int LAT_ALU  = 1;   // single-cycle result, fully forwardable
    localparam int LAT_LOAD = 2;   // load: one bubble for an adjacent consumer
    localparam int LAT_MUL  = 4;   // fixed multi-cycle multiplier

    // Countdown field width inside an entry. It is fixed here so the struct
    // can live in the package; it must be at least the top-level LAT_W. The
    // upper bits stay zero when LAT_W is narrower and are trimmed away.
    localparam int SB_CNT_W = 16;

    typedef struct packed {
        logic                pending;
        logic                is_var;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks whether a single architectural register has
// a result in flight, whether it is variable latency, and the cycles left
// before a fixed-latency result becomes forwardable.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_hit,   // EX instruction writes this register
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             wb_hit,      // variable-latency writeback to this register
    output logic             pending,
    output logic             is_var
);

    sb_entry_t        entry;
    logic [LAT_W-1:0] lat_minus2;

    // Remaining scoreboard cycles once the bypass cycle has been accounted for.
    assign lat_minus2 = issue_lat - LAT_W'(2);

    // Entry update: reset, then issue (youngest writer wins), then countdown
    // or writeback release.
    // NOTE: sequential state uses non-blocking assignments so every entry
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '0;
        end else if (issue_hit) begin
            if (issue_lat == LAT_W'(LAT_VAR)) begin
                entry.pending <= 1'b1;
                entry.is_var  <= 1'b1;
                entry.cnt     <= '0;
            end else if (issue_lat > LAT_W'(LAT_LOAD)) begin
                entry.pending <= 1'b1;
                entry.is_var  <= 1'b0;
                entry.cnt     <= SB_CNT_W'(lat_minus2);
            end else begin
                // A fast writer supersedes any older in-flight result (WAW).
                entry <= '0;
            end
        end else if (entry.pending && !entry.is_var) begin
            entry.cnt <= entry.cnt - SB_CNT_W'(1);
            if (entry.cnt == SB_CNT_W'(1)) begin
                entry.pending <= 1'b0;
            end
        end else if (entry.pending && entry.is_var && wb_hit) begin
            entry.pending <= 1'b0;
            entry.is_var  <= 1'b0;
        end
    end

    assign pending = entry.pending;
    assign is_var  = entry.is_var;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard. Holds one entry per architectural register
// for results still in flight and raises a stall while any used source of
// the ID instruction cannot yet be forwarded. Also counts stalled cycles.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int IDX_W = $clog2(NREGS),
    parameter int NSRC  = 2,
    parameter int LAT_W = 4,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [IDX_W-1:0]      issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic                  wb_valid,
    input  logic [IDX_W-1:0]      wb_rd,
    input  logic [NSRC*IDX_W-1:0] src_idx,
    input  logic [NSRC-1:0]       src_used,
    output logic [NSRC-1:0]       src_stall,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      stall_count
);

    // Every encodable index gets a slot so lookups never go out of range;
    // slots at or above NREGS (and register 0) read as never pending.
    localparam int NSLOT = 1 << IDX_W;

    logic [NSLOT-1:0] pending;
    logic [NSLOT-1:0] is_var;
    logic             issue_we;
    logic             issue_late;

    assign issue_we   = issue_valid && issue_writes && (issue_rd != '0);
    // The EX result is not forwardable next cycle unless it is a 1-cycle op.
    assign issue_late = issue_we &&
                        ((issue_lat == LAT_W'(LAT_VAR)) || (issue_lat >= LAT_W'(LAT_LOAD)));

    assign pending[0] = 1'b0;
    assign is_var[0]  = 1'b0;

    for (genvar r = 1; r < NSLOT; r++) begin : g_entry
        if (r < NREGS) begin : g_live
            sb_entry #(
                .LAT_W (LAT_W)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .issue_hit (issue_we && (issue_rd == IDX_W'(r))),
                .issue_lat (issue_lat),
                .wb_hit    (wb_valid && (wb_rd == IDX_W'(r))),
                .pending   (pending[r]),
                .is_var    (is_var[r])
            );
        end else begin : g_unused
            assign pending[r] = 1'b0;
            assign is_var[r]  = 1'b0;
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [IDX_W-1:0] src;
        logic             bypass_hit;
        logic             wb_fwd;

        assign src        = src_idx[k*IDX_W +: IDX_W];
        assign bypass_hit = issue_late && (issue_rd == src);
        // A same-cycle writeback of a variable-latency result is forwarded,
        // unless a younger writer in EX targets the same register.
        assign wb_fwd     = wb_valid && (wb_rd == src) && is_var[src] && !bypass_hit;
        assign src_stall[k] = src_used[k] && (src != '0) &&
                              (bypass_hit || pending[src]) && !wb_fwd;
    end

    assign load_use_stall = |src_stall;

    // Saturating count of cycles in which decode is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (load_use_stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Stimulus pushes the hand-computed
// expected outputs for each cycle into a queue; a monitor on the falling edge
// pops and compares against the DUT.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREGS = 32;
    localparam int IDX_W = 5;
    localparam int NSRC  = 2;
    localparam int LAT_W = 4;
    localparam int CNT_W = 4;   // narrow so saturation is reachable

    logic                  clk;
    logic                  rst;
    logic                  issue_valid;
    logic                  issue_writes;
    logic [IDX_W-1:0]      issue_rd;
    logic [LAT_W-1:0]      issue_lat;
    logic                  wb_valid;
    logic [IDX_W-1:0]      wb_rd;
    logic [NSRC*IDX_W-1:0] src_idx;
    logic [NSRC-1:0]       src_used;
    logic [NSRC-1:0]       src_stall;
    logic                  load_use_stall;
    logic [CNT_W-1:0]      stall_count;

    hazard_scoreboard #(
        .NREGS (NREGS),
        .IDX_W (IDX_W),
        .NSRC  (NSRC),
        .LAT_W (LAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_writes   (issue_writes),
        .issue_rd       (issue_rd),
        .issue_lat      (issue_lat),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .src_idx        (src_idx),
        .src_used       (src_used),
        .src_stall      (src_stall),
        .load_use_stall (load_use_stall),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [1:0]       ss;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {stall,lus,cnt}=%h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name,
                  64'({src_stall, load_use_stall, stall_count}),
                  64'({e.ss, |e.ss, e.cnt}));
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for it.
    task automatic vec(input string name, input bit iv, input bit wr, input int rd,
                       input int lat, input bit wv, input int wrd, input int s0,
                       input int s1, input logic [1:0] used, input logic [1:0] ss,
                       input int cnt);
        exp_t e;
        issue_valid  = iv;
        issue_writes = wr;
        issue_rd     = IDX_W'(rd);
        issue_lat    = LAT_W'(lat);
        wb_valid     = wv;
        wb_rd        = IDX_W'(wrd);
        src_idx      = {IDX_W'(s1), IDX_W'(s0)};
        src_used     = used;
        e.name = name;
        e.ss   = ss;
        e.cnt  = CNT_W'(cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_writes = 0; issue_rd = '0; issue_lat = '0;
        wb_valid = 0; wb_rd = '0; src_idx = '0; src_used = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        //   name        iv wr rd  lat       wv wrd s0  s1  used   ss     cnt
        vec("reset_idle", 0, 0, 0,  0,        0, 0,  0,  0,  2'b00, 2'b00, 0);

        // Load x5, adjacent consumer: one stall cycle.
        vec("load_t",     1, 1, 5,  LAT_LOAD, 0, 0,  5,  0,  2'b01, 2'b01, 0);
        vec("load_t1",    0, 0, 0,  0,        0, 0,  5,  0,  2'b01, 2'b00, 1);

        // Mul x7 lat 4 read on source 1: three stall cycles.
        vec("mul_t",      1, 1, 7,  LAT_MUL,  0, 0,  0,  7,  2'b10, 2'b10, 1);
        vec("mul_t1",     0, 0, 0,  0,        0, 0,  0,  7,  2'b10, 2'b10, 2);
        vec("mul_t2",     0, 0, 0,  0,        0, 0,  0,  7,  2'b10, 2'b10, 3);
        vec("mul_t3",     0, 0, 0,  0,        0, 0,  0,  7,  2'b10, 2'b00, 4);

        // Div x9 variable latency, released by writeback at t+5.
        vec("div_t",      1, 1, 9,  LAT_VAR,  0, 0,  9,  0,  2'b01, 2'b01, 4);
        vec("div_t1",     0, 0, 0,  0,        0, 0,  9,  0,  2'b01, 2'b01, 5);
        vec("div_t2",     0, 0, 0,  0,        0, 0,  9,  9,  2'b11, 2'b11, 6);
        vec("div_t3",     0, 0, 0,  0,        0, 0,  9,  0,  2'b01, 2'b01, 7);
        vec("div_t4",     0, 0, 0,  0,        0, 0,  9,  0,  2'b01, 2'b01, 8);
        vec("div_wb",     0, 0, 0,  0,        1, 9,  9,  9,  2'b11, 2'b00, 9);
        vec("div_after",  0, 0, 0,  0,        0, 0,  9,  9,  2'b11, 2'b00, 9);

        // x0 destination and x0 consumer never stall.
        vec("x0_dst",     1, 1, 0,  LAT_MUL,  0, 0,  0,  0,  2'b01, 2'b00, 9);
        vec("x0_next",    0, 0, 0,  0,        0, 0,  0,  0,  2'b01, 2'b00, 9);

        // Matching sources with src_used=0 never stall; x6 drains in 3 edges.
        vec("unused_t",   1, 1, 6,  LAT_MUL,  0, 0,  6,  6,  2'b00, 2'b00, 9);
        vec("unused_t1",  0, 0, 0,  0,        0, 0,  6,  6,  2'b00, 2'b00, 9);
        vec("unused_t2",  0, 0, 0,  0,        0, 0,  6,  6,  2'b00, 2'b00, 9);
        vec("x6_clear",   0, 0, 0,  0,        0, 0,  6,  0,  2'b01, 2'b00, 9);

        // Single-cycle ALU producer: no stall.
        vec("alu_t",      1, 1, 8,  LAT_ALU,  0, 0,  8,  0,  2'b01, 2'b00, 9);

        // WAW: x3 lat 6 superseded by x3 lat 1.
        vec("waw_t",      1, 1, 3,  6,        0, 0,  0,  0,  2'b00, 2'b00, 9);
        vec("waw_t1",     1, 1, 3,  LAT_ALU,  0, 0,  0,  0,  2'b00, 2'b00, 9);
        vec("waw_t2",     0, 0, 0,  0,        0, 0,  3,  0,  2'b01, 2'b00, 9);
        vec("waw_t3",     0, 0, 0,  0,        0, 0,  3,  0,  2'b01, 2'b00, 9);

        // Lat 3: two stall cycles (bypass, then one scoreboard cycle).
        vec("l3_t",       1, 1, 10, 3,        0, 0,  10, 0,  2'b01, 2'b01, 9);
        vec("l3_t1",      0, 0, 0,  0,        0, 0,  10, 0,  2'b01, 2'b01, 10);
        vec("l3_t2",      0, 0, 0,  0,        0, 0,  10, 0,  2'b01, 2'b00, 11);

        // Writeback to a fixed-latency entry does not release it.
        vec("nv_t",       1, 1, 11, LAT_MUL,  0, 0,  11, 0,  2'b01, 2'b01, 11);
        vec("nv_t1",      0, 0, 0,  0,        1, 11, 11, 0,  2'b01, 2'b01, 12);
        vec("nv_t2",      0, 0, 0,  0,        0, 0,  11, 0,  2'b01, 2'b01, 13);
        vec("nv_t3",      0, 0, 0,  0,        0, 0,  11, 0,  2'b01, 2'b00, 14);

        // Mid-run reset discards x4 (cnt=3) and ignores the issue in the rst cycle.
        vec("rs_t",       1, 1, 4,  5,        0, 0,  0,  0,  2'b00, 2'b00, 14);
        rst = 1'b1;
        vec("rs_rst",     1, 1, 4,  LAT_VAR,  0, 0,  0,  0,  2'b00, 2'b00, 14);
        rst = 1'b0;
        vec("rs_t2",      0, 0, 0,  0,        0, 0,  4,  0,  2'b01, 2'b00, 0);
        vec("rs_t3",      0, 0, 0,  0,        0, 0,  4,  4,  2'b11, 2'b00, 0);

        // Long variable-latency stall saturates the 4-bit counter at 15.
        for (int i = 0; i < 18; i++) begin
            vec($sformatf("sat_%0d", i), i == 0, i == 0, 13, LAT_VAR, 0, 0, 13, 0,
                2'b01, 2'b01, (i > 15) ? 15 : i);
        end
        vec("sat_wb",     0, 0, 0,  0,        1, 13, 13, 0,  2'b01, 2'b00, 15);
        vec("sat_hold",   0, 0, 0,  0,        0, 0,  13, 0,  2'b01, 2'b00, 15);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected records never compared, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
